// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with TLAST sideband, occupancy flags, synchronous flush and
// an optional packet mode that holds the output until a full packet is stored.
module axis_fifo_pkt #(
  parameter int OUTW     = 24,
  parameter int DEPTH    = 19,
  parameter int AF_TH    = 16,
  parameter int AE_TH    = 2,
  parameter int PKT_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [OUTW-1:0]              IN_AXIS_TDATA,
  input  logic                         IN_AXIS_TLAST,
  input  logic                         IN_AXIS_TVALID,
  output logic                         IN_AXIS_TREADY,
  output logic [OUTW-1:0]              OUT_AXIS_TDATA,
  output logic                         OUT_AXIS_TLAST,
  output logic                         OUT_AXIS_TVALID,
  input  logic                         OUT_AXIS_TREADY,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_CNT   = CNTW'(AF_TH);
  localparam logic [CNTW-1:0] AE_CNT   = CNTW'(AE_TH);

  logic [OUTW:0]   mem [DEPTH];
  logic [OUTW:0]   rdata;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   tail_next;
  logic            full;
  logic            wr;
  logic            rd;
  logic            pkt_inc;
  logic            pkt_dec;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign full           = (count == FULL_CNT);
  assign OUT_AXIS_TDATA = rdata[OUTW-1:0];
  assign OUT_AXIS_TLAST = rdata[OUTW];
  assign almost_full    = (count >= AF_CNT);
  assign almost_empty   = (count <= AE_CNT);

  always_comb begin
    OUT_AXIS_TVALID = 1'b0;
    if (PKT_MODE != 0) begin
      // A packet longer than the buffer would never complete; let it stream.
      OUT_AXIS_TVALID = (pkt_count != '0) | full;
    end else begin
      OUT_AXIS_TVALID = (count != '0);
    end
    rd             = OUT_AXIS_TVALID & OUT_AXIS_TREADY;
    IN_AXIS_TREADY = ~reset & ~flush & (~full | rd);
    wr             = IN_AXIS_TVALID & IN_AXIS_TREADY;
    tail_next      = rd ? wrap_inc(tail) : tail;
    pkt_inc        = wr & IN_AXIS_TLAST;
    pkt_dec        = rd & OUT_AXIS_TLAST;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr) head <= wrap_inc(head);
      tail <= tail_next;
      case ({wr, rd})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + CNTW'(1);
        2'b01:   pkt_count <= pkt_count - CNTW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Read port follows tail_next; a write landing on that slot is forwarded
  // so a beat into an empty (or emptying) FIFO is visible the next cycle.
  always_ff @(posedge clk) begin
    if (wr) mem[head] <= {IN_AXIS_TLAST, IN_AXIS_TDATA};
    if (wr && (head == tail_next)) begin
      rdata <= {IN_AXIS_TLAST, IN_AXIS_TDATA};
    end else begin
      rdata <= mem[tail_next];
    end
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Randomised scoreboard bench: a stream-mode and a packet-mode FIFO checked
// each cycle against queue-based reference models.
module tb_axis_fifo_pkt;

  localparam int OUTW = 24;
  localparam int NPH  = 6;

  logic            clk;
  logic            reset;
  logic            flush     [2];
  logic [OUTW-1:0] in_data   [2];
  logic            in_last   [2];
  logic            in_valid  [2];
  logic            out_ready [2];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d t=%0t actual=%0h expected=%0h", name, lane, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D  = (g == 0) ? 5 : 4;
    localparam int AF = (g == 0) ? 4 : 3;
    localparam int AE = 1;
    localparam int PM = g;
    localparam int CW = $clog2(D + 1);

    logic [OUTW-1:0] odata;
    logic            olast;
    logic            ovalid;
    logic            iready;
    logic            af;
    logic            ae;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   pcnt;

    axis_fifo_pkt #(
      .OUTW(OUTW), .DEPTH(D), .AF_TH(AF), .AE_TH(AE), .PKT_MODE(PM)
    ) dut (
      .clk(clk), .reset(reset), .flush(flush[g]),
      .IN_AXIS_TDATA(in_data[g]), .IN_AXIS_TLAST(in_last[g]),
      .IN_AXIS_TVALID(in_valid[g]), .IN_AXIS_TREADY(iready),
      .OUT_AXIS_TDATA(odata), .OUT_AXIS_TLAST(olast),
      .OUT_AXIS_TVALID(ovalid), .OUT_AXIS_TREADY(out_ready[g]),
      .count(cnt), .almost_full(af), .almost_empty(ae), .pkt_count(pcnt)
    );

    logic [OUTW:0] q[$];

    always @(negedge clk) begin : mon
      int   n;
      int   npk;
      logic ev;
      logic er;
      logic rd;
      logic wr;
      if (reset) begin
        q.delete();
      end else begin
        n   = q.size();
        npk = 0;
        foreach (q[i]) if (q[i][OUTW]) npk++;
        if (PM != 0) ev = (npk > 0) || (n == D);
        else         ev = (n != 0);
        er = !flush[g] && ((n < D) || (ev && out_ready[g]));
        rd = ev && out_ready[g];
        wr = in_valid[g] && er;
        check("tready",       g, 32'(iready), 32'(er));
        check("tvalid",       g, 32'(ovalid), 32'(ev));
        check("count",        g, 32'(cnt),    32'(n));
        check("pkt_count",    g, 32'(pcnt),   32'(npk));
        check("almost_full",  g, 32'(af),     32'(n >= AF));
        check("almost_empty", g, 32'(ae),     32'(n <= AE));
        if (ev) begin
          check("tdata", g, 32'(odata), 32'(q[0][OUTW-1:0]));
          check("tlast", g, 32'(olast), 32'(q[0][OUTW]));
        end
        if (rd) void'(q.pop_front());
        if (flush[g]) q.delete();
        else if (wr) q.push_back({in_last[g], in_data[g]});
      end
    end
  end

  // Percent probabilities per phase: in_valid, out_ready, tlast.
  int unsigned ph_v [NPH] = '{95, 90, 50, 100, 20, 70};
  int unsigned ph_r [NPH] = '{ 5, 50, 90, 100, 90, 70};
  int unsigned ph_l [NPH] = '{ 0, 20, 30,  50, 10, 25};

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    for (int g = 0; g < 2; g++) begin
      flush[g] = 1'b0; in_data[g] = '0; in_last[g] = 1'b0;
      in_valid[g] = 1'b0; out_ready[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
          in_valid[g]  = ($urandom_range(99) < ph_v[p]);
          out_ready[g] = ($urandom_range(99) < ph_r[p]);
          in_last[g]   = ($urandom_range(99) < ph_l[p]);
          in_data[g]   = OUTW'($urandom);
          flush[g]     = ($urandom_range(149) == 0) && (p != 0);
          if (p == 1 && c == 100) begin
            flush[g] = 1'b1; in_valid[g] = 1'b1;
          end
          if (p == 3 && c == 120) begin
            flush[g] = 1'b1; in_valid[g] = 1'b1;
          end
        end
        if ((p == 2 && c == 150) || (p == 3 && c == 120)) reset = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; flush[g] = 1'b0; out_ready[g] = 1'b1;
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_fifo_pkt.md
Name: axis_fifo_pkt

Overview:
- Parametrised successor to the team's output FIFO: AXI-Stream buffer between the convolution datapath and the downstream consumer.
- Adds arbitrary (non-power-of-2) depth, TLAST sideband, occupancy/threshold flags, a synchronous flush, and an optional packet mode that holds output until a complete packet is stored.
- Memory is an inferred dual-port array: synchronous write, read addressed by next-tail.

Parameters:
- OUTW, 24, data width in bits (>=1).
- DEPTH, 19, entry capacity (>=2, any integer).
- AF_TH, 16, almost_full asserts when count >= AF_TH (1..DEPTH).
- AE_TH, 2, almost_empty asserts when count <= AE_TH (0..DEPTH-1).
- PKT_MODE, 0, 0 = stream mode; 1 = packet mode (output gated on stored TLAST).
- CNTW, $clog2(DEPTH+1), localparam, width of count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents
- IN_AXIS_TDATA  in  OUTW  write data
- IN_AXIS_TLAST  in  1  end-of-packet marker
- IN_AXIS_TVALID  in  1  write valid
- IN_AXIS_TREADY  out  1  write ready
- OUT_AXIS_TDATA  out  OUTW  read data
- OUT_AXIS_TLAST  out  1  stored TLAST of head entry
- OUT_AXIS_TVALID  out  1  read valid
- OUT_AXIS_TREADY  in  1  read ready
- count  out  CNTW  entries stored (0..DEPTH)
- almost_full  out  1  count >= AF_TH
- almost_empty  out  1  count <= AE_TH
- pkt_count  out  CNTW  complete packets stored (TLAST entries held)

Behaviour:
- One clock domain: clk. reset is synchronous, active-high.
- Reset (and flush): head=0, tail=0, count=0, pkt_count=0. Next cycle: OUT_AXIS_TVALID=0, IN_AXIS_TREADY=1, almost_full=0, almost_empty=1. OUT_AXIS_TDATA/TLAST undefined while TVALID=0.
- wr = IN_AXIS_TVALID & IN_AXIS_TREADY. rd = OUT_AXIS_TVALID & OUT_AXIS_TREADY.
- Head and tail wrap from DEPTH-1 to 0 explicitly; no power-of-2 assumption.
- tail_next = tail+1 (wrapped) when rd, else tail. The memory reads at tail_next, so head data is presented the cycle after any pop.
- IN_AXIS_TREADY = (count < DEPTH) | rd. Full-plus-pop accepts a write in the same cycle. The combinational OUT_AXIS_TREADY -> IN_AXIS_TREADY path is intentional.
- Stream mode: OUT_AXIS_TVALID = (count != 0).
- Packet mode: OUT_AXIS_TVALID = (pkt_count != 0).
  - If count==DEPTH and pkt_count==0, TVALID is forced to 1. This prevents deadlock on a packet longer than DEPTH; the packet then streams through.
- Latency: a beat written at edge N is valid on the output from cycle N+1 (stream mode, FIFO empty before the write).
- count update: wr&!rd -> +1; rd&!wr -> -1; both or neither -> hold.
- pkt_count update: +1 on wr with TLAST=1; -1 on rd with OUT_AXIS_TLAST=1. Both in the same cycle -> hold.
- Full and empty are never ambiguous: count is tracked explicitly.
- No overflow or underflow: a write when full without a pop has TREADY=0; a pop when empty has TVALID=0.
- Output stability: while TVALID=1 and TREADY=0, TDATA and TLAST hold, including across simultaneous writes.
- flush: takes effect at the edge where it is high. IN_AXIS_TREADY=0 that cycle and any input beat is discarded. reset has priority over flush.
- Flags are combinational from count: almost_full = (count >= AF_TH), almost_empty = (count <= AE_TH).
- Reset mid-packet discards partial packets; no state survives.

Test Plan:
- Stream, DEPTH=5: push 1,2,3 with OUT_TREADY=0 -> count=3, TVALID=1, TDATA=1. Then OUT_TREADY=1 for 3 cycles -> outputs 1,2,3, then count=0, TVALID=0.
- Full wrap, DEPTH=5: push 10..14 -> TREADY=0, count=5, almost_full=1 (AF_TH=4). Then pop+push 15 in one cycle -> accepted, count stays 5. Draining yields 11..15 in order, with head/tail wrapping past 4.
- Latency: empty FIFO, write 0xABCDEF at edge N -> TVALID=1 and TDATA=0xABCDEF at cycle N+1. With continuous TREADY=1 and one write per cycle, one beat out per cycle with no bubbles.
- Packet mode, DEPTH=8: push A,B (TLAST=0) -> TVALID=0, pkt_count=0. Push C (TLAST=1) -> next cycle TVALID=1, pkt_count=1. Drain A,B,C (C with TLAST=1) -> pkt_count=0.
- Packet mode oversize, DEPTH=4: push 4 beats, none with TLAST -> TVALID forced 1. Pop 1 and push beat 5 (TLAST=1) -> stream continues and pkt_count reaches 1.
- Flush/reset: with count=3, assert flush for one cycle while IN_TVALID=1 -> beat dropped. Next cycle count=0, TVALID=0, TREADY=1. Repeat with reset -> same result, and reset wins when both are asserted.
